// File: rtl/calc_sequencer_pkg.sv
// rtl/calc_sequencer_pkg.sv - shared widths, FSM encodings and ALU op codes for the calculator sequencer
package calc_sequencer_pkg;

    localparam int DATA_W = 16;
    localparam int ALU_W  = 32;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;
    localparam logic [1:0] S_WAIT_REL = 2'd3;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    function automatic logic [ALU_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ALU_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, saturating debounce counter and rising-edge press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic deb_o,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          deb_q;

    // Any low sample restarts the count, so short pulses never reach saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEB_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign deb_o   = (cnt_q == CW'(DEB_CYCLES));
    assign press_o = deb_o & ~deb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_o;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - press-driven FSM that captures op/operand, drives the ALU and updates the accumulator
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic              clk,
    input  logic              btnac,
    input  logic              btnd,
    input  logic [3:0]        alu_op_in,
    input  logic [DATA_W-1:0] sw,
    input  logic [ALU_W-1:0]  result,
    output logic [3:0]        alu_op,
    output logic [ALU_W-1:0]  op1,
    output logic [ALU_W-1:0]  op2,
    output logic [DATA_W-1:0] led,
    output logic              busy
);

    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic              deb;
    logic              press;
    logic [1:0]        state_q, state_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] sw_q, sw_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              unused_result_hi;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (btnac),
        .btn_i  (btnd),
        .deb_o  (deb),
        .press_o(press)
    );

    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        sw_d     = sw_q;
        acc_d    = acc_q;
        lat_d    = lat_q;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d  = S_ISSUE;
                    alu_op_d = alu_op_in;
                    sw_d     = sw;
                    lat_d    = LW'(ALU_LAT - 1);
                end
            end
            S_ISSUE: begin
                if (lat_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            S_WRITE: begin
                acc_d   = result[DATA_W-1:0];
                state_d = S_WAIT_REL;
            end
            default: begin
                // Holding the button keeps deb high, so one press yields one operation.
                if (!deb) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge btnac) begin
        if (btnac) begin
            state_q  <= S_IDLE;
            alu_op_q <= '0;
            sw_q     <= '0;
            acc_q    <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            sw_q     <= sw_d;
            acc_q    <= acc_d;
            lat_q    <= lat_d;
        end
    end

    assign unused_result_hi = ^result[ALU_W-1:DATA_W];

    assign alu_op = alu_op_q;
    assign op1    = sext(acc_q);
    assign op2    = sext(sw_q);
    assign led    = acc_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - scoreboard bench for calc_sequencer with a behavioural ALU
module tb_calc_sequencer;
    import calc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        btnac = 1'b0;
    logic        btnd = 1'b0;
    logic [3:0]  alu_op_in = '0;
    logic [15:0] sw = '0;
    logic [31:0] result;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2;
    logic [15:0] led;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    logic        busy_prev = 1'b0;

    calc_sequencer #(.DEB_CYCLES(4), .ALU_LAT(1)) dut (
        .clk(clk), .btnac(btnac), .btnd(btnd), .alu_op_in(alu_op_in), .sw(sw),
        .result(result), .alu_op(alu_op), .op1(op1), .op2(op2), .led(led), .busy(busy)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always_comb begin
        case (alu_op)
            ALU_ADD: result = op1 + op2;
            ALU_SUB: result = op1 - op2;
            ALU_AND: result = op1 & op2;
            ALU_OR:  result = op1 | op2;
            ALU_SLT: result = {31'd0, $signed(op1) < $signed(op2)};
            default: result = 32'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each completed operation ends with busy falling; led must then match the oldest expectation.
    always @(negedge clk) begin
        if (busy_prev && !busy && !btnac) begin
            if (exp_q.size() == 0) begin
                check("unexpected_op", 32'd1, 32'd0);
            end else begin
                check("sb_led", {16'd0, led}, {16'd0, exp_q.pop_front()});
            end
        end
        busy_prev = busy;
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] s,
                          input int hold, input logic [15:0] exp_led,
                          input logic [31:0] exp_op1, input logic [31:0] exp_op2,
                          input bit chg_sw);
        logic [15:0] old_led;
        old_led = led;
        alu_op_in = op;
        sw = s;
        exp_q.push_back(exp_led);
        @(posedge clk); #1 btnd = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({name, "_busy_pre"}, {31'd0, busy}, 32'd0);
        @(posedge clk); @(negedge clk);
        check({name, "_busy_issue"}, {31'd0, busy}, 32'd1);
        check({name, "_alu_op"}, {28'd0, alu_op}, {28'd0, op});
        check({name, "_op1"}, op1, exp_op1);
        check({name, "_op2"}, op2, exp_op2);
        if (chg_sw) begin
            sw = 16'h1234;
            alu_op_in = ALU_OR;
        end
        @(posedge clk); @(negedge clk);
        check({name, "_led_p2"}, {16'd0, led}, {16'd0, old_led});
        if (chg_sw) begin
            check({name, "_op2_held"}, op2, exp_op2);
            check({name, "_aluop_held"}, {28'd0, alu_op}, {28'd0, op});
        end
        @(posedge clk); @(negedge clk);
        check({name, "_led_p3"}, {16'd0, led}, {16'd0, exp_led});
        repeat (hold - 9) @(posedge clk);
        @(negedge clk);
        check({name, "_busy_held"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1 btnd = 1'b0;
        wait_idle({name, "_busy_fall"});
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int busy_seen;
        logic [15:0] led_before;

        // Reset with the clock stopped must act immediately.
        #2 btnac = 1'b1;
        #3 btnac = 1'b0;
        #1;
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_op1", op1, 32'd0);
        check("rst_op2", op2, 32'd0);
        clk_en = 1'b1;
        repeat (3) @(posedge clk);

        run_op("add5", ALU_ADD, 16'h0005, 10, 16'h0005, 32'd0, 32'd5, 1'b0);

        busy_seen = 0;
        led_before = led;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk); #1 btnd = 1'b1;
            repeat (3) @(posedge clk);
            #1 btnd = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (busy) busy_seen++;
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("glitch_busy", busy_seen, 0);
        check("glitch_led", {16'd0, led}, {16'd0, led_before});

        run_op("hold", ALU_ADD, 16'h0001, 50, 16'h0006, 32'd5, 32'd1, 1'b0);
        run_op("sub1", ALU_SUB, 16'h0001, 10, 16'h0005, 32'd6, 32'd1, 1'b0);
        run_op("wrap", ALU_ADD, 16'hFFFF, 10, 16'h0004, 32'd5, 32'hFFFF_FFFF, 1'b1);

        alu_op_in = ALU_ADD;
        sw = 16'h0007;
        @(posedge clk); #1 btnd = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort_busy_issue", {31'd0, busy}, 32'd1);
        btnac = 1'b1;
        #1;
        check("abort_led", {16'd0, led}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_alu_op", {28'd0, alu_op}, 32'd0);
        btnd = 1'b0;
        repeat (2) @(posedge clk);
        #1 btnac = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort_no_write", {16'd0, led}, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        run_op("sub_after", ALU_SUB, 16'h0001, 10, 16'hFFFF, 32'd0, 32'd1, 1'b0);

        repeat (4) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
